match_controller: RTL and testbench
===================================

# match_controller

Parametrised game-match controller: pre-match countdown, match timer, per-player BCD score counters with pause, and winner/tie resolution at full time. Generalises the single-player scoreboard FSM to N players, configurable digit count and configurable prep/match durations. Sits between the debounced button/sensor front end and the seven-segment display multiplexer. All timing derives internally from a `clk` prescaler.

## Interface
- `NUM_PLAYERS`, 2: number of independent score channels, 1..4.
- `SCORE_DIGITS`, 2: BCD digits per player score, 1..4.
- `TICKS_PER_SEC`, 100_000_000: `clk` cycles per game second, ≥2.
- `PREP_SEC`, 3: pre-match countdown length in seconds, 1..9.
- `MATCH_SEC`, 30: match length in seconds, 1..99.

- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: single-cycle pulse; starts or restarts a match.
- `stop` in 1: single-cycle pulse; toggles pause during PLAY.
- `goal` in NUM_PLAYERS: per-player single-cycle goal pulses, synchronised upstream.
- `state` out 2: 0 IDLE, 1 PREP, 2 PLAY, 3 FINISH.
- `paused` out 1: pause flag.
- `time_bcd` out 8: remaining seconds as {tens, ones} BCD.
- `score_bcd` out NUM_PLAYERS*4*SCORE_DIGITS: player p occupies slice [p*4*SCORE_DIGITS +: 4*SCORE_DIGITS], least-significant digit lowest.
- `sec_tick` out 1: one-cycle pulse on each counted second.
- `done` out 1: high while in FINISH.
- `winner` out max(1,clog2(NUM_PLAYERS)): index of the top scorer, valid while `done`.
- `tie` out 1: high while `done` if two or more players share the top score.

## Operation
- States:
  - IDLE: waits for `start`.
  - PREP: counts PREP_SEC down to 1.
  - PLAY: counts MATCH_SEC down to 0.
  - FINISH: holds final scores and time 00 until `start`.
- Transitions:
  - IDLE/FINISH + `start` → PREP. Sets time=PREP_SEC, clears all scores, clears `paused`, clears the prescaler.
  - PREP: each `sec_tick` decrements time. A tick with time==1 → PLAY, loads time=MATCH_SEC, clears the prescaler.
  - PLAY: each `sec_tick` decrements time. A tick with time==1 → FINISH with time=0.
  - `start` is ignored in PREP and PLAY.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 in PREP and PLAY; `sec_tick` is asserted combinationally when it equals TICKS_PER_SEC-1.
  - Held at 0 in IDLE and FINISH.
  - Frozen, with `sec_tick` low, while `paused`.
- Pause:
  - `stop` in PLAY toggles `paused`. `stop` in any other state is ignored.
  - `paused` is cleared on leaving PLAY.
- Scores:
  - Player p increments by 1 in BCD when goal[p]=1, state==PLAY and !paused. The carry ripples across digits.
  - At all-9s the score saturates and holds.
  - Simultaneous goals on different players each count.
  - A goal in the same cycle as the final PLAY tick counts.
  - Goals in other states are ignored.
- Winner: combinational from the registered scores.
  - `winner` is the lowest index holding the maximum score.
  - `tie`=1 if any other player equals that maximum.
  - With NUM_PLAYERS=1: `winner`=0, `tie`=0.
  - Both outputs read 0 when not `done`.
- Time is held in binary internally; `time_bcd` is its tens/ones conversion.

## Timing
- Reset values:
  - `state`=IDLE, `paused`=0, `time_bcd`=00.
  - All scores 0.
  - `sec_tick`=0, `done`=0, `winner`=0, `tie`=0.
  - Prescaler 0.
- `rst` overrides all inputs in the same cycle and aborts a match at any point.
- `start` sampled at edge k: `state`=PREP from cycle k+1.
- PREP lasts exactly PREP_SEC*TICKS_PER_SEC cycles. PLAY lasts MATCH_SEC*TICKS_PER_SEC cycles plus the cycles spent paused.
- Goal at edge k: `score_bcd` updated in cycle k+1.
- `stop` at edge k: `paused` toggles in cycle k+1.
- `winner`/`tie` are valid from the first FINISH cycle.

## Test plan
Parameters for all scenarios: NUM_PLAYERS=2, SCORE_DIGITS=2, TICKS_PER_SEC=4, PREP_SEC=3, MATCH_SEC=12.

- **Full match:** `start` pulse at cycle 0.
  - `time_bcd` reads 03,02,01 over cycles 1–12.
  - PLAY starts at cycle 13 with time 12.
  - FINISH at cycle 61 with time 00 and `done`=1.
- **Score and winner:** 3 goals on player0 and 5 on player1 during PLAY.
  - At FINISH, `score_bcd`=0x0503, `winner`=1, `tie`=0.
  - Equal counts of 4 give `winner`=0, `tie`=1.
- **Pause:** `stop` at PLAY time 10, hold 20 cycles, `stop` again.
  - Time frozen at 10, no `sec_tick`, goals ignored while paused.
  - FINISH is delayed by exactly 20 cycles.
- **BCD and saturation:** 9 goals on player0 → score 0x09; next goal → 0x10; 99 goals → 0x99; further goals → still 0x99.
  - Simultaneous goal[1:0]=11 increments both players.
- **Edge and ignore cases:**
  - Goal on the final PLAY tick cycle is counted.
  - `start` during PLAY has no effect.
  - `start` in FINISH → PREP with scores cleared to 0.
- **Reset mid-match:** `rst` at PLAY time 07 with scores 0x02/0x01.
  - Next cycle: IDLE, all outputs at their reset values.

Source files
------------

// File: rtl/match_controller.sv
// rtl/match_controller.sv - match FSM: prep countdown, match timer, per-player BCD scores, winner/tie
module match_controller #(
    parameter int NUM_PLAYERS   = 2,
    parameter int SCORE_DIGITS  = 2,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int PREP_SEC      = 3,
    parameter int MATCH_SEC     = 30,
    localparam int SW = 4 * SCORE_DIGITS,
    localparam int WW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int PW = $clog2(TICKS_PER_SEC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [NUM_PLAYERS-1:0]    goal,
    output logic [1:0]                state,
    output logic                      paused,
    output logic [7:0]                time_bcd,
    output logic [NUM_PLAYERS*SW-1:0] score_bcd,
    output logic                      sec_tick,
    output logic                      done,
    output logic [WW-1:0]             winner,
    output logic                      tie
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        PLAY   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                    state_r, state_nxt;
    logic [PW-1:0]             presc_r;
    logic [6:0]                time_r;
    logic                      paused_r;
    logic [NUM_PLAYERS*SW-1:0] score_r, score_nxt;
    logic                      counting, tick, last_sec;

    // The prescaler only advances while a countdown is live and not paused.
    assign counting = (state_r == PREP) || (state_r == PLAY && !paused_r);
    assign tick     = counting && (presc_r == PW'(TICKS_PER_SEC - 1));
    assign last_sec = tick && (time_r == 7'd1);

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE, FINISH: if (start)    state_nxt = PREP;
            PREP:         if (last_sec) state_nxt = PLAY;
            PLAY:         if (last_sec) state_nxt = FINISH;
            default:      state_nxt = IDLE;
        endcase
    end

    // Per-player BCD increment with digit carry; an all-9s score saturates.
    logic       carry, all_nine;
    logic [3:0] dig;
    always_comb begin
        score_nxt = score_r;
        carry     = 1'b0;
        all_nine  = 1'b0;
        dig       = 4'd0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            all_nine = 1'b1;
            for (int d = 0; d < SCORE_DIGITS; d++)
                if (score_r[p*SW + d*4 +: 4] != 4'd9) all_nine = 1'b0;
            if (goal[p] && !paused_r && !all_nine) begin
                carry = 1'b1;
                for (int d = 0; d < SCORE_DIGITS; d++) begin
                    dig = score_r[p*SW + d*4 +: 4];
                    if (carry) begin
                        if (dig == 4'd9) begin
                            dig = 4'd0;
                        end else begin
                            dig   = dig + 4'd1;
                            carry = 1'b0;
                        end
                    end
                    score_nxt[p*SW + d*4 +: 4] = dig;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            presc_r  <= '0;
            time_r   <= 7'd0;
            paused_r <= 1'b0;
            score_r  <= '0;
        end else begin
            state_r <= state_nxt;
            case (state_r)
                IDLE, FINISH: begin
                    presc_r <= '0;
                    if (start) begin
                        time_r   <= 7'(PREP_SEC);
                        score_r  <= '0;
                        paused_r <= 1'b0;
                    end
                end
                PREP: begin
                    if (tick) begin
                        presc_r <= '0;
                        time_r  <= last_sec ? 7'(MATCH_SEC) : time_r - 7'd1;
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                PLAY: begin
                    score_r <= score_nxt;
                    if (last_sec) begin
                        time_r   <= 7'd0;
                        paused_r <= 1'b0;
                        presc_r  <= '0;
                    end else begin
                        if (stop) paused_r <= ~paused_r;
                        if (tick) begin
                            presc_r <= '0;
                            time_r  <= time_r - 7'd1;
                        end else if (!paused_r) begin
                            presc_r <= presc_r + PW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Lowest index wins on equal scores; BCD orders the same as binary.
    logic [SW-1:0] best, cur;
    logic [WW-1:0] best_idx;
    logic          any_tie;
    always_comb begin
        best     = score_r[SW-1:0];
        cur      = '0;
        best_idx = '0;
        any_tie  = 1'b0;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            cur = score_r[p*SW +: SW];
            if (cur > best) begin
                best     = cur;
                best_idx = WW'(p);
            end
        end
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            cur = score_r[p*SW +: SW];
            if (p != int'(best_idx) && cur == best) any_tie = 1'b1;
        end
    end

    assign state     = state_r;
    assign paused    = paused_r;
    assign time_bcd  = {4'(time_r / 7'd10), 4'(time_r % 7'd10)};
    assign score_bcd = score_r;
    assign sec_tick  = tick;
    assign done      = (state_r == FINISH);
    assign winner    = done ? best_idx : '0;
    assign tie       = done && any_tie;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - directed scoreboard bench for match_controller
module tb_match_controller;

    logic        clk = 1'b0;
    logic        rst, start, start2, stop;
    logic [1:0]  goal;

    logic [1:0]  state, st2;
    logic        paused, pa2, sec_tick, tk2, done, dn2, winner, wn2, tie, ti2;
    logic [7:0]  time_bcd, tb2;
    logic [15:0] score_bcd, sc2;

    int total = 0;
    int bad   = 0;
    int m0, m1, n, cnt;
    bit saw_tick, time_moved;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    match_controller #(.NUM_PLAYERS(2), .SCORE_DIGITS(2), .TICKS_PER_SEC(4),
                       .PREP_SEC(3), .MATCH_SEC(12)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .goal(goal),
        .state(state), .paused(paused), .time_bcd(time_bcd), .score_bcd(score_bcd),
        .sec_tick(sec_tick), .done(done), .winner(winner), .tie(tie));

    // Longer second so one match has room for >100 goals.
    match_controller #(.NUM_PLAYERS(2), .SCORE_DIGITS(2), .TICKS_PER_SEC(16),
                       .PREP_SEC(3), .MATCH_SEC(12)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .stop(1'b0), .goal(goal),
        .state(st2), .paused(pa2), .time_bcd(tb2), .score_bcd(sc2),
        .sec_tick(tk2), .done(dn2), .winner(wn2), .tie(ti2));

    function automatic int sat_inc(input int v);
        return (v >= 99) ? 99 : v + 1;
    endfunction

    function automatic logic [15:0] pack(input int a, input int b);
        return {4'(b / 10), 4'(b % 10), 4'(a / 10), 4'(a % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goal_step(input logic [1:0] g, input bit counts);
        goal = g;
        if (counts) begin
            if (g[0]) m0 = sat_inc(m0);
            if (g[1]) m1 = sat_inc(m1);
        end
        exp_q.push_back(pack(m0, m1));
        step();
        goal = 2'b00;
        chk("score_sb", 32'(score_bcd), 32'(exp_q.pop_front()));
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag, output int waited);
        waited = 0;
        while (state !== s && waited < 300) begin
            step();
            waited++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  32'(state),     32'd0);
        chk({tag, "_paused"}, 32'(paused),    32'd0);
        chk({tag, "_time"},   32'(time_bcd),  32'h00);
        chk({tag, "_score"},  32'(score_bcd), 32'h0000);
        chk({tag, "_tick"},   32'(sec_tick),  32'd0);
        chk({tag, "_done"},   32'(done),      32'd0);
        chk({tag, "_winner"}, 32'(winner),    32'd0);
        chk({tag, "_tie"},    32'(tie),       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; stop = 1'b0; goal = 2'b00;
        m0 = 0; m1 = 0;
        step(); step();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Full match with 3/5 goals
        start = 1'b1; step(); start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            chk("prep_state", 32'(state), 32'd1);
            chk("prep_time", 32'(time_bcd), 32'(3 - (i - 1) / 4));
            step();
        end
        chk("play_state", 32'(state), 32'd2);
        chk("play_time", 32'(time_bcd), 32'h12);
        for (int i = 0; i < 8; i++)
            goal_step({(i < 5) ? 1'b1 : 1'b0, (i < 3) ? 1'b1 : 1'b0}, 1'b1);
        wait_state(2'd3, "finish_reached", n);
        chk("finish_cycle", 32'(21 + n), 32'd61);
        chk("finish_time", 32'(time_bcd), 32'h00);
        chk("finish_done", 32'(done), 32'd1);
        chk("final_score", 32'(score_bcd), 32'h0503);
        chk("winner_p1", 32'(winner), 32'd1);
        chk("no_tie", 32'(tie), 32'd0);

        // Restart from FINISH, tie match, start ignored in PLAY
        start = 1'b1; m0 = 0; m1 = 0; step(); start = 1'b0;
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_score", 32'(score_bcd), 32'h0000);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_tie", 32'(tie), 32'd0);
        wait_state(2'd2, "tie_play", n);
        for (int i = 0; i < 4; i++) goal_step(2'b11, 1'b1);
        start = 1'b1; step(); start = 1'b0;
        chk("start_in_play", 32'(state), 32'd2);
        chk("start_in_play_score", 32'(score_bcd), 32'h0404);
        wait_state(2'd3, "tie_finish", n);
        chk("tie_winner", 32'(winner), 32'd0);
        chk("tie_flag", 32'(tie), 32'd1);

        // Pause for 20 cycles at time 10, goal on the final tick
        start = 1'b1; m0 = 0; m1 = 0; step(); start = 1'b0;
        wait_state(2'd2, "pause_play", n);
        cnt = 0;
        while (time_bcd !== 8'h10 && cnt < 100) begin step(); cnt++; end
        chk("reach_t10", 32'(time_bcd), 32'h10);
        stop = 1'b1; step(); stop = 1'b0; cnt++;
        chk("paused_set", 32'(paused), 32'd1);
        saw_tick = 1'b0; time_moved = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (sec_tick !== 1'b0) saw_tick = 1'b1;
            if (time_bcd !== 8'h10) time_moved = 1'b1;
            goal_step(2'b01, 1'b0);
            cnt++;
        end
        if (sec_tick !== 1'b0) saw_tick = 1'b1;
        if (time_bcd !== 8'h10) time_moved = 1'b1;
        stop = 1'b1; step(); stop = 1'b0; cnt++;
        chk("no_tick_paused", 32'(saw_tick), 32'd0);
        chk("time_frozen", 32'(time_moved), 32'd0);
        chk("paused_clear", 32'(paused), 32'd0);
        n = 0;
        while (!(sec_tick === 1'b1 && time_bcd === 8'h01) && n < 200) begin step(); cnt++; n++; end
        chk("final_tick_seen", 32'(time_bcd), 32'h01);
        goal_step(2'b10, 1'b1); cnt++;
        chk("pause_finish", 32'(state), 32'd3);
        chk("finish_delay", 32'(cnt), 32'd68);
        chk("pause_winner", 32'(winner), 32'd1);

        // BCD carry and saturation on the long-second instance
        start2 = 1'b1; step(); start2 = 1'b0;
        n = 0;
        while (st2 !== 2'd2 && n < 200) begin step(); n++; end
        chk("sat_play", 32'(st2), 32'd2);
        m0 = 0;
        for (int i = 1; i <= 101; i++) begin
            goal = 2'b01;
            m0 = sat_inc(m0);
            exp_q.push_back(pack(m0, 0));
            step();
            goal = 2'b00;
            chk("sat_sb", 32'(sc2), 32'(exp_q.pop_front()));
            if (i == 9)   chk("bcd_09", 32'(sc2[7:0]), 32'h09);
            if (i == 10)  chk("bcd_10", 32'(sc2[7:0]), 32'h10);
            if (i == 99)  chk("bcd_99", 32'(sc2[7:0]), 32'h99);
            if (i == 101) chk("bcd_sat", 32'(sc2[7:0]), 32'h99);
        end
        goal = 2'b11; step(); goal = 2'b00;
        chk("simul_goal", 32'(sc2), 32'h0199);

        // Reset in the middle of PLAY
        start = 1'b1; m0 = 0; m1 = 0; step(); start = 1'b0;
        wait_state(2'd2, "rst_play", n);
        goal_step(2'b11, 1'b1);
        goal_step(2'b01, 1'b1);
        n = 0;
        while (time_bcd !== 8'h07 && n < 100) begin step(); n++; end
        chk("rst_t07", 32'(time_bcd), 32'h07);
        chk("rst_pre_score", 32'(score_bcd), 32'h0102);
        rst = 1'b1; step(); rst = 1'b0;
        chk_reset_vals("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
